// File: rtl/motor_pwm_driver_if.sv
// Command and pin bundle for the dual H-bridge PWM driver.
// The controller side drives the enable and duty commands; the driver side
// returns the four bridge pins, the period strobe and the sticky fault flag.
interface motor_pwm_driver_if;
    logic       enable;
    logic [7:0] lm;
    logic [7:0] lmn;
    logic [7:0] rm;
    logic [7:0] rmn;
    logic       l_in1;
    logic       l_in2;
    logic       r_in1;
    logic       r_in2;
    logic       period_tick;
    logic       fault;

    modport master (
        output enable, lm, lmn, rm, rmn,
        input  l_in1, l_in2, r_in1, r_in2, period_tick, fault
    );

    modport slave (
        input  enable, lm, lmn, rm, rmn,
        output l_in1, l_in2, r_in1, r_in2, period_tick, fault
    );
endinterface

// File: rtl/motor_pwm_driver.sv
// Dual-channel H-bridge PWM driver with slew-limited duty ramping and a
// dead interval on direction reversal. Both channels share one prescaler
// and one PWM counter; commands are sampled once per PWM period.
module motor_pwm_driver #(
    parameter int PRESCALE     = 500,
    parameter int PERIOD       = 100,
    parameter int RAMP_STEP    = 4,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                clk_50,
    input  logic                rst_n,
    motor_pwm_driver_if.slave   bus
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]      CNT_LAST   = 8'(PERIOD - 1);
    localparam logic [7:0]      PERIOD_8   = 8'(PERIOD);
    localparam logic [7:0]      STEP_8     = 8'(RAMP_STEP);
    // The period in which DEAD is entered counts as the first dead period.
    localparam logic [7:0]      DEAD_LOAD  = (DEAD_PERIODS > 1) ? 8'(DEAD_PERIODS - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_REV  = 2'd2,
        S_DEAD = 2'd3
    } state_e;

    typedef struct packed {
        state_e     st;
        logic [7:0] duty;
        logic [7:0] dead;
    } chan_t;

    localparam chan_t CH_RESET = '{st: S_IDLE, duty: 8'd0, dead: 8'd0};

    // Move cur toward tgt by at most one ramp step, landing exactly on tgt.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] res;
        if (cur < tgt) begin
            res = ((tgt - cur) > STEP_8) ? (cur + STEP_8) : tgt;
        end else begin
            res = ((cur - tgt) > STEP_8) ? (cur - STEP_8) : tgt;
        end
        return res;
    endfunction

    // One per-period step of a channel given the sampled signed target.
    // A running direction first ramps to zero duty; only a sample that finds
    // duty already at zero leaves the direction (to IDLE or DEAD).
    function automatic chan_t chan_step(input chan_t c, input logic pos, input logic neg,
                                        input logic [7:0] mag);
        chan_t n;
        n = c;
        case (c.st)
            S_IDLE: begin
                if (pos) begin
                    n.st   = S_FWD;
                    n.duty = ramp_toward(8'd0, mag);
                end else if (neg) begin
                    n.st   = S_REV;
                    n.duty = ramp_toward(8'd0, mag);
                end else begin
                    n.duty = 8'd0;
                end
            end
            S_FWD: begin
                if (pos) begin
                    n.duty = ramp_toward(c.duty, mag);
                end else if (c.duty != 8'd0) begin
                    n.duty = ramp_toward(c.duty, 8'd0);
                end else if (neg) begin
                    n.st   = S_DEAD;
                    n.dead = DEAD_LOAD;
                end else begin
                    n.st   = S_IDLE;
                end
            end
            S_REV: begin
                if (neg) begin
                    n.duty = ramp_toward(c.duty, mag);
                end else if (c.duty != 8'd0) begin
                    n.duty = ramp_toward(c.duty, 8'd0);
                end else if (pos) begin
                    n.st   = S_DEAD;
                    n.dead = DEAD_LOAD;
                end else begin
                    n.st   = S_IDLE;
                end
            end
            S_DEAD: begin
                if (c.dead != 8'd0) begin
                    n.dead = c.dead - 8'd1;
                end else if (pos) begin
                    n.st   = S_FWD;
                    n.duty = ramp_toward(8'd0, mag);
                end else if (neg) begin
                    n.st   = S_REV;
                    n.duty = ramp_toward(8'd0, mag);
                end else begin
                    n.st   = S_IDLE;
                    n.duty = 8'd0;
                end
            end
            default: begin
                n = CH_RESET;
            end
        endcase
        return n;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          fault_q, fault_d;
    chan_t         ch_q [2];
    chan_t         ch_d [2];
    logic [1:0]    in1_q, in1_d;
    logic [1:0]    in2_q, in2_d;
    logic [7:0]    fwd_s [2];
    logic [7:0]    rev_s [2];
    logic [7:0]    mag_s [2];
    logic [1:0]    pos_s, neg_s, both_s;

    // Shared prescaler and PWM counter; the period strobe is registered from
    // the next-count terminal condition so it lines up with the counters.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = {PW{1'b0}};
            if (cnt_q == CNT_LAST) begin
                cnt_d = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
        tick_d = (presc_d == PRESC_LAST) && (cnt_d == CNT_LAST);
    end

    // Per-channel target decode, FSM step on the period strobe, and pin
    // levels computed from next-state values so they are registered in step.
    always_comb begin
        fwd_s[0] = bus.lm;
        rev_s[0] = bus.lmn;
        fwd_s[1] = bus.rm;
        rev_s[1] = bus.rmn;
        for (int c = 0; c < 2; c++) begin
            both_s[c] = (fwd_s[c] != 8'd0) && (rev_s[c] != 8'd0);
            pos_s[c]  = bus.enable && (fwd_s[c] != 8'd0) && (rev_s[c] == 8'd0);
            neg_s[c]  = bus.enable && (rev_s[c] != 8'd0) && (fwd_s[c] == 8'd0);
            if (pos_s[c]) begin
                mag_s[c] = (fwd_s[c] > PERIOD_8) ? PERIOD_8 : fwd_s[c];
            end else if (neg_s[c]) begin
                mag_s[c] = (rev_s[c] > PERIOD_8) ? PERIOD_8 : rev_s[c];
            end else begin
                mag_s[c] = 8'd0;
            end
            if (tick_q) begin
                ch_d[c] = chan_step(ch_q[c], pos_s[c], neg_s[c], mag_s[c]);
            end else begin
                ch_d[c] = ch_q[c];
            end
            in1_d[c] = (ch_d[c].st == S_FWD) && (cnt_d < ch_d[c].duty);
            in2_d[c] = (ch_d[c].st == S_REV) && (cnt_d < ch_d[c].duty);
        end
        fault_d = fault_q | (tick_q & (|both_s));
    end

    // State and output registers; reset forces every pin low at once.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= {PW{1'b0}};
            cnt_q   <= 8'd0;
            tick_q  <= 1'b0;
            fault_q <= 1'b0;
            in1_q   <= 2'b00;
            in2_q   <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                ch_q[c] <= CH_RESET;
            end
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            fault_q <= fault_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            for (int c = 0; c < 2; c++) begin
                ch_q[c] <= ch_d[c];
            end
        end
    end

    assign bus.l_in1       = in1_q[0];
    assign bus.l_in2       = in2_q[0];
    assign bus.r_in1       = in1_q[1];
    assign bus.r_in2       = in2_q[1];
    assign bus.period_tick = tick_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver. The stimulus process issues
// commands and, at each PWM period boundary, advances a signed-level model
// of each channel and queues the expected high-time per pin for the next
// period. A monitor accumulates pin high-times and checks them at every
// period strobe the design produces.
module tb_motor_pwm_driver;

    localparam int PRESCALE     = 2;
    localparam int PERIOD       = 10;
    localparam int RAMP_STEP    = 4;
    localparam int DEAD_PERIODS = 2;
    localparam int PER_CYC      = PRESCALE * PERIOD;

    typedef struct {
        int l1;
        int l2;
        int r1;
        int r2;
        int flt;
    } exp_t;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;

    motor_pwm_driver_if bus_if ();

    motor_pwm_driver #(
        .PRESCALE     (PRESCALE),
        .PERIOD       (PERIOD),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .bus    (bus_if)
    );

    always #5 clk_50 = ~clk_50;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    int   k = 0;
    int   ticks_exp  = 0;
    int   ticks_seen = 0;

    logic       p_en;
    logic [7:0] p_lm, p_lmn, p_rm, p_rmn;

    // Model: signed level = dir * mag; dead counts remaining dead periods.
    int m_mag[2];
    int m_dir[2];
    int m_dead[2];
    int m_fault;

    int a_l1, a_l2, a_r1, a_r2, ovl;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] rnd_cmd();
        case ($urandom_range(0, 3))
            0, 3:    return 8'd0;
            1:       return 8'($urandom_range(1, 10));
            default: return 8'($urandom_range(11, 255));
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_mag[c]  = 0;
            m_dir[c]  = 0;
            m_dead[c] = 0;
        end
        m_fault = 0;
    endtask

    // Apply the period-boundary rules to the commands currently on the bus.
    task automatic model_sample();
        int   f, r, t, a, sg, tt;
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            f = (c == 0) ? int'(bus_if.lm)  : int'(bus_if.rm);
            r = (c == 0) ? int'(bus_if.lmn) : int'(bus_if.rmn);
            if (f != 0 && r != 0) m_fault = 1;
            t = 0;
            if (bus_if.enable && f != 0 && r == 0) t = imin(f, PERIOD);
            else if (bus_if.enable && r != 0 && f == 0) t = -imin(r, PERIOD);
            a  = (t < 0) ? -t : t;
            sg = (t > 0) ? 1 : ((t < 0) ? -1 : 0);
            if (m_dead[c] > 0) begin
                m_dead[c]--;
                if (m_dead[c] == 0 && t != 0) begin
                    m_dir[c] = sg;
                    m_mag[c] = imin(RAMP_STEP, a);
                end
            end else if (m_dir[c] == 0) begin
                if (t != 0) begin
                    m_dir[c] = sg;
                    m_mag[c] = imin(RAMP_STEP, a);
                end
            end else begin
                tt = t * m_dir[c];
                if (m_mag[c] == 0 && tt <= 0) begin
                    m_dir[c] = 0;
                    if (t != 0) m_dead[c] = DEAD_PERIODS;
                end else if (tt > 0) begin
                    if (m_mag[c] < tt) m_mag[c] = imin(m_mag[c] + RAMP_STEP, tt);
                    else               m_mag[c] = imax(m_mag[c] - RAMP_STEP, tt);
                end else begin
                    m_mag[c] = imax(m_mag[c] - RAMP_STEP, 0);
                end
            end
        end
        e.l1  = (m_dir[0] > 0) ? m_mag[0] * PRESCALE : 0;
        e.l2  = (m_dir[0] < 0) ? m_mag[0] * PRESCALE : 0;
        e.r1  = (m_dir[1] > 0) ? m_mag[1] * PRESCALE : 0;
        e.r2  = (m_dir[1] < 0) ? m_mag[1] * PRESCALE : 0;
        e.flt = m_fault;
        exp_q.push_back(e);
        ticks_exp++;
    endtask

    // One clock: check the strobe position, scramble commands early in the
    // period, apply the planned commands mid-period, model at the boundary.
    task automatic step_cycle();
        check("period_tick", int'(bus_if.period_tick), int'((k % PER_CYC) == PER_CYC - 1));
        if (k % PER_CYC == 0) begin
            bus_if.enable = 1'($urandom);
            bus_if.lm     = 8'($urandom);
            bus_if.lmn    = 8'($urandom);
            bus_if.rm     = 8'($urandom);
            bus_if.rmn    = 8'($urandom);
        end
        if (k % PER_CYC == PER_CYC / 2) begin
            bus_if.enable = p_en;
            bus_if.lm     = p_lm;
            bus_if.lmn    = p_lmn;
            bus_if.rm     = p_rm;
            bus_if.rmn    = p_rmn;
        end
        if (k % PER_CYC == PER_CYC - 1) model_sample();
        @(negedge clk_50);
        k++;
    endtask

    task automatic run_periods(input int n, input logic en, input logic [7:0] lm,
                               input logic [7:0] lmn, input logic [7:0] rm, input logic [7:0] rmn);
        p_en  = en;
        p_lm  = lm;
        p_lmn = lmn;
        p_rm  = rm;
        p_rmn = rmn;
        repeat (n * PER_CYC) step_cycle();
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_l_in1"}, int'(bus_if.l_in1), 0);
        check({tag, "_l_in2"}, int'(bus_if.l_in2), 0);
        check({tag, "_r_in1"}, int'(bus_if.r_in1), 0);
        check({tag, "_r_in2"}, int'(bus_if.r_in2), 0);
        check({tag, "_tick"},  int'(bus_if.period_tick), 0);
        check({tag, "_fault"}, int'(bus_if.fault), 0);
    endtask

    task automatic release_reset();
        exp_t e0;
        model_reset();
        exp_q.delete();
        ticks_exp  = 0;
        ticks_seen = 0;
        e0 = '{0, 0, 0, 0, 0};
        exp_q.push_back(e0);
        k = 0;
        rst_n = 1'b1;
    endtask

    // Assert reset at the current negedge, confirm outputs drop without a
    // clock edge, then hold and release on a later negedge.
    task automatic mid_reset(input string tag);
        check({tag, "_tick_count"}, ticks_seen, ticks_exp);
        rst_n = 1'b0;
        #1;
        check_all_low(tag);
        repeat (3) @(negedge clk_50);
        release_reset();
    endtask

    // Scoreboard monitor: accumulate pin high-time, compare on each strobe.
    always @(negedge clk_50) begin
        if (!rst_n) begin
            a_l1 = 0; a_l2 = 0; a_r1 = 0; a_r2 = 0; ovl = 0;
        end else begin
            a_l1 += int'(bus_if.l_in1);
            a_l2 += int'(bus_if.l_in2);
            a_r1 += int'(bus_if.r_in1);
            a_r2 += int'(bus_if.r_in2);
            if ((bus_if.l_in1 && bus_if.l_in2) || (bus_if.r_in1 && bus_if.r_in2)) ovl++;
            if (bus_if.period_tick) begin
                ticks_seen++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 0, 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("l_in1_high", a_l1, e.l1);
                    check("l_in2_high", a_l2, e.l2);
                    check("r_in1_high", a_r1, e.r1);
                    check("r_in2_high", a_r2, e.r2);
                    check("fault", int'(bus_if.fault), e.flt);
                    check("pin_overlap", ovl, 0);
                end
                a_l1 = 0; a_l2 = 0; a_r1 = 0; a_r2 = 0; ovl = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1 ms");
        $fatal(1);
    end

    initial begin
        bus_if.enable = 1'b0;
        bus_if.lm     = 8'd0;
        bus_if.lmn    = 8'd0;
        bus_if.rm     = 8'd0;
        bus_if.rmn    = 8'd0;
        repeat (3) @(negedge clk_50);
        check_all_low("reset");
        release_reset();

        // Ramp up from reset: 4, 8, 10 ticks.
        run_periods(5, 1'b1, 8'd10, 8'd0, 8'd0, 8'd0);
        // Settle at duty 8, then reverse: 4, 0, dead, dead, 4, 6.
        run_periods(1, 1'b1, 8'd8, 8'd0, 8'd0, 8'd0);
        run_periods(8, 1'b1, 8'd0, 8'd6, 8'd0, 8'd0);
        // Right running, then both directions commanded: target 0, fault sticks.
        run_periods(3, 1'b1, 8'd0, 8'd6, 8'd10, 8'd0);
        run_periods(4, 1'b1, 8'd0, 8'd6, 8'd5, 8'd5);
        run_periods(2, 1'b1, 8'd0, 8'd6, 8'd0, 8'd5);
        // Over-range command saturates at full period.
        run_periods(9, 1'b1, 8'd200, 8'd0, 8'd0, 8'd0);
        // Enable dropped at full duty: ramp down to IDLE with no dead time.
        run_periods(5, 1'b0, 8'd200, 8'd0, 8'd0, 8'd9);

        // Randomised commands, one set per period.
        for (int i = 0; i < 40; i++) begin
            run_periods(1, ($urandom_range(0, 7) != 0), rnd_cmd(), rnd_cmd(), rnd_cmd(), rnd_cmd());
        end

        // Drive the left channel into DEAD and reset in the middle of it.
        run_periods(9, 1'b1, 8'd10, 8'd0, 8'd0, 8'd0);
        run_periods(4, 1'b1, 8'd0, 8'd10, 8'd0, 8'd0);
        repeat (PER_CYC / 2) step_cycle();
        mid_reset("rst_dead");

        // Restart from zero, then reset while the left pin is high.
        run_periods(4, 1'b1, 8'd200, 8'd0, 8'd3, 8'd0);
        repeat (3) step_cycle();
        mid_reset("rst_high");

        run_periods(3, 1'b1, 8'd0, 8'd7, 8'd0, 8'd0);
        check("final_tick_count", ticks_seen, ticks_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
